mul_div_unit: RTL and testbench

Iterative multi-cycle RV32M multiply/divide unit, parametrised in operand width. Sits in the execute stage beside the single-cycle ALU. It decodes func_3 for the M-extension ops and raises a stall to the hazard unit while it computes. It produces one result bit-step per cycle behind a start/busy/done handshake.

---
 rtl/mul_div_unit.sv | 100 ++++++++++
 tb/tb_mul_div_unit.sv | 104 ++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide, one shift-add/sub step per cycle behind start/busy/done.
// Optional MDU_EARLY_OUT_EN: multiplies with a zero operand finish without iterating.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func_3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic            neg_q, spec_q, done_q;
  logic [XLEN-1:0] m_q, hi_q, lo_q, hi_d, lo_d, result_q;
  logic            sa, sb, a_neg, b_neg, div_zero, ovf, zero_mul, special, ge;
  logic [XLEN-1:0] ma, mb, spec_res, quo, rem, fin;
  logic [XLEN:0]   sum, tr, diff;
  logic [2*XLEN-1:0] prod, prod_n;
  assign sa    = ~func_3[0] | (func_3 == 3'b001);
  assign sb    = func_3[2] ? ~func_3[0] : ~func_3[1];
  assign a_neg = sa & operand_a[XLEN-1];
  assign b_neg = sb & operand_b[XLEN-1];
  assign ma    = a_neg ? -operand_a : operand_a;
  assign mb    = b_neg ? -operand_b : operand_b;
  assign div_zero = func_3[2] & (operand_b == '0);
  assign ovf      = func_3[2] & ~func_3[0] & (operand_a == {1'b1, {(XLEN-1){1'b0}}}) & (&operand_b);
`ifdef MDU_EARLY_OUT_EN
  assign zero_mul = ~func_3[2] & ((operand_a == '0) | (operand_b == '0));
`else
  assign zero_mul = 1'b0;
`endif
  assign special  = div_zero | ovf | zero_mul;
  assign spec_res = div_zero ? (func_3[1] ? operand_a : '1) : ovf ? (func_3[1] ? '0 : operand_a) : '0;
  // Multiply: {hi,lo} shifts right with m added into hi; divide: dividend shifts out of lo into hi.
  assign sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign tr   = {hi_q, lo_q[XLEN-1]};
  assign diff = tr - {1'b0, m_q};
  assign ge   = ~diff[XLEN];
  assign hi_d = op_q[2] ? (ge ? diff[XLEN-1:0] : tr[XLEN-1:0]) : sum[XLEN:1];
  assign lo_d = op_q[2] ? {lo_q[XLEN-2:0], ge} : {sum[0], lo_q[XLEN-1:1]};
  assign prod   = {hi_q, lo_q};
  assign prod_n = neg_q ? -prod : prod;
  assign quo    = neg_q ? -lo_q : lo_q;
  assign rem    = neg_q ? -hi_q : hi_q;
  assign fin    = spec_q ? lo_q : op_q[2] ? (op_q[1] ? rem : quo) :
                  (op_q[1:0] == 2'b00 ? prod_n[XLEN-1:0] : prod_n[2*XLEN-1:XLEN]);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      done_q   <= 1'b0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          op_q    <= func_3;
          neg_q   <= (func_3[2] & func_3[1]) ? a_neg : a_neg ^ b_neg;
          spec_q  <= special;
          cnt_q   <= CW'(XLEN-1);
          m_q     <= func_3[2] ? mb : ma;
          hi_q    <= '0;
          lo_q    <= special ? spec_res : func_3[2] ? ma : mb;
          state_q <= special ? FINISH : CALC;
        end
        CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= FINISH;
        end
        FINISH: begin
          result_q <= fin;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy   = state_q != IDLE;
  assign stall  = busy & ~done_q;
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit (XLEN=32) with hand-computed results and latencies.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  func_3 = '0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic        busy, stall, done;
  logic [31:0] result;
  int n_vec = 0, n_err = 0;
`ifdef MDU_EARLY_OUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif
  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .func_3(func_3),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // inj >= 0 pulses a conflicting start that many edges after the accepted one
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int inj);
    int n;
    logic st_ok;
    @(negedge clk);
    start = 1'b1; func_3 = f; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    st_ok = 1'b1;
    while (!done && n < 100) begin
      st_ok &= stall & busy;
      @(negedge clk);
      start = (n == inj - 1);
      if (n == inj - 1) begin func_3 = 3'b000; operand_a = 32'd1; operand_b = 32'd1; end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " result"}, {32'd0, result}, {32'd0, exp});
    chk({tag, " stall-while-busy"}, {63'd0, st_ok}, 64'd1);
    chk({tag, " stall-at-done"}, {63'd0, stall}, 64'd0);
  endtask
  initial begin
    int dn;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset stall", {63'd0, stall}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset result", {32'd0, result}, 64'd0);
    @(negedge clk); rst = 1'b0;
    run_op("MUL 7*-3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, -1);
    run_op("MULHU ff*ff",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, -1);
    run_op("MULH -1*-1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, -1);
    run_op("MULHSU -1*2",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, -1);
    run_op("MUL 2^16^2",    3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 33, -1);
    run_op("MULHU 2^16^2",  3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 33, -1);
    run_op("DIV -20/3",     3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33, -1);
    run_op("REM -20/3",     3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33, -1);
    run_op("DIV 20/-3",     3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33, -1);
    run_op("REM 20/-3",     3'b110, 32'd20,       32'hFFFFFFFD, 32'h00000002, 33, -1);
    run_op("DIVU 20/3",     3'b101, 32'd20,       32'd3,        32'd6,        33, -1);
    run_op("REMU 20/3",     3'b111, 32'd20,       32'd3,        32'd2,        33, -1);
    run_op("DIVU /0",       3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 1,  -1);
    run_op("REM /0",        3'b110, 32'h1234,     32'd0,        32'h00001234, 1,  -1);
    run_op("DIV ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  -1);
    run_op("REM ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  -1);
    run_op("DIVU ignore",   3'b101, 32'd20,       32'd3,        32'd6,        33, 5);
    run_op("MUL 0*5",       3'b000, 32'd0,        32'd5,        32'd0,        ZLAT, -1);
    // abort a DIVU ten edges in; the previous result must clear and no done may follow
    @(negedge clk);
    start = 1'b1; func_3 = 3'b101; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort result", {32'd0, result}, 64'd0);
    chk("abort done", {63'd0, done}, 64'd0);
    @(negedge clk); rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort no done", 64'(dn), 64'd0);
    run_op("DIVU after rst", 3'b101, 32'd100, 32'd7, 32'd14, 33, -1);
    run_op("REMU b2b",       3'b111, 32'd100, 32'd7, 32'd2,  33, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
